// File: rtl/tangent_lut.sv
// Integer-degree tangent lookup producing an IEEE-754 binary64 result.
// The 91-entry tan table is generated at elaboration; runtime logic only folds the angle and fixes the sign.
module tangent_lut #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      en_tangent,
   input  logic [1:0]                quadrant,
   input  logic [DATA_WIDTH-1:0]     data_in,
   output logic [2*DATA_WIDTH-1:0]   data_out
);

   localparam int OW = 2 * DATA_WIDTH;
   localparam logic [63:0] QNAN    = 64'h7FF8_0000_0000_0000;
   localparam logic [63:0] POS_INF = 64'h7FF0_0000_0000_0000;

   // Fixed-point pi with FB fractional bits; wide enough that every table
   // entry rounds to nearest-even binary64 exactly.
   localparam int FB = 124;
   localparam logic [255:0] PI_FX = 256'h3243F6A8885A308D313198A2E0370734;

   function automatic logic [63:0] tan_bits(input int k);
      logic [255:0] x, x2, term, s_pos, s_neg, c_pos, c_neg, s, c, q, m, rem, half;
      int p, e;
      if (k == 0 || k > 90)
         return 64'h0;
      if (k == 90)
         return POS_INF;
      x  = (PI_FX * 256'(k)) / 256'd180;
      x2 = (x * x) >> FB;
      term  = x;
      s_pos = x;
      s_neg = '0;
      for (int n = 1; n <= 30; n++) begin
         term = ((term * x2) >> FB) / 256'((2 * n) * (2 * n + 1));
         if (n % 2 == 1) s_neg = s_neg + term;
         else            s_pos = s_pos + term;
      end
      term  = 256'd1 << FB;
      c_pos = term;
      c_neg = '0;
      for (int n = 1; n <= 30; n++) begin
         term = ((term * x2) >> FB) / 256'((2 * n - 1) * (2 * n));
         if (n % 2 == 1) c_neg = c_neg + term;
         else            c_pos = c_pos + term;
      end
      s = s_pos - s_neg;
      c = c_pos - c_neg;
      q = (s << FB) / c;
      p = 0;
      for (int i = 0; i < 256; i++)
         if (q[i]) p = i;
      m    = q >> (p - 52);
      rem  = q - (m << (p - 52));
      half = 256'd1 << (p - 53);
      if (rem > half || (rem == half && m[0]))
         m = m + 256'd1;
      e = p - FB + 1023;
      if (m[53]) begin
         m = m >> 1;
         e = e + 1;
      end
      return {1'b0, e[10:0], m[51:0]};
   endfunction

   logic [63:0] rom [0:127];

   for (genvar k = 0; k < 128; k++) begin : g_rom
      localparam logic [63:0] ENTRY = tan_bits(k);
      assign rom[k] = ENTRY;
   end

   logic          out_of_range;
   logic [8:0]    a9;
   logic [7:0]    r;
   logic          fold;
   logic [6:0]    idx;
   logic [63:0]   mag;
   logic          sign;
   logic [OW-1:0] result;
   logic          unused_quadrant_hi;

   assign unused_quadrant_hi = quadrant[1];

   always_comb begin
      out_of_range = data_in >= DATA_WIDTH'(360);
      a9   = data_in[8:0];
      r    = (a9 >= 9'd180) ? 8'(a9 - 9'd180) : a9[7:0];
      fold = r > 8'd90;
      idx  = fold ? 7'(8'd180 - r) : r[6:0];
      mag  = rom[idx];
      sign = fold ^ quadrant[0];
      result = '0;
      if (out_of_range)
         result = OW'(QNAN);
      else if (mag != 64'h0)
         result = OW'({sign, mag[62:0]});
   end

   always_ff @(posedge clk) begin
      if (reset_n)
         data_out <= '0;
      else if (en_tangent)
         data_out <= result;
   end

endmodule

// File: tb/tb_tangent_lut.sv
// Scoreboard bench for tangent_lut: driver queues expectations from a real-arithmetic
// tan model, a negedge monitor pops and compares them against data_out.
module tb_tangent_lut;

   localparam real PI = 3.14159265358979323846;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        en_tangent = 1'b0;
   logic [1:0]  quadrant = 2'd0;
   logic [31:0] data_in = 32'd0;
   logic [63:0] data_out;

   always #5 clk = ~clk;

   tangent_lut #(.DATA_WIDTH(32)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .en_tangent(en_tangent),
      .quadrant(quadrant),
      .data_in(data_in),
      .data_out(data_out)
   );

   typedef struct {
      bit          exact;
      logic [63:0] bits;
      real         val;
      int          due;
      string       name;
   } exp_t;

   exp_t sbq[$];
   exp_t last_exp;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t model(input logic [31:0] a, input logic [1:0] q);
      exp_t e;
      int d;
      real v;
      e.exact = 1'b1;
      e.val   = 0.0;
      e.due   = 0;
      e.name  = "";
      e.bits  = 64'h0;
      if (a >= 32'd360) begin
         e.bits = 64'h7FF8_0000_0000_0000;
         return e;
      end
      d = int'(a) % 180;
      if (d == 0) begin
         e.bits = 64'h0;
      end else if (d == 90) begin
         e.bits = q[0] ? 64'hFFF0_0000_0000_0000 : 64'h7FF0_0000_0000_0000;
      end else begin
         v = $tan(real'(d) * PI / 180.0);
         if (q[0]) v = -v;
         e.exact = 1'b0;
         e.val   = v;
         e.bits  = $realtobits(v);
         case (d)
            30:  begin e.exact = 1'b1; e.bits = 64'h3FE279A74590331C; end
            45:  begin e.exact = 1'b1; e.bits = 64'h3FF0000000000000; end
            60:  begin e.exact = 1'b1; e.bits = 64'h3FFBB67AE8584CAA; end
            120: begin e.exact = 1'b1; e.bits = 64'hBFFBB67AE8584CAA; end
            135: begin e.exact = 1'b1; e.bits = 64'hBFF0000000000000; end
            150: begin e.exact = 1'b1; e.bits = 64'hBFE279A74590331C; end
            default: ;
         endcase
         if (e.exact && q[0]) e.bits[63] = ~e.bits[63];
      end
      return e;
   endfunction

   task automatic check(input exp_t e);
      bit  ok;
      real got_r, diff, mag;
      total++;
      if (e.exact) begin
         ok = (data_out === e.bits);
      end else begin
         got_r = $bitstoreal(data_out);
         diff  = got_r - e.val;
         if (diff < 0.0) diff = -diff;
         mag = (e.val < 0.0) ? -e.val : e.val;
         ok = (data_out[63] == (e.val < 0.0)) && (data_out[62:52] != 11'h7FF)
              && (diff <= 1.0e-12 * mag);
      end
      if (!ok) begin
         bad++;
         $display("FAIL %s: data_out=%h expected=%h (cycle %0d)", e.name, data_out, e.bits, cyc);
      end
   endtask

   task automatic issue(input bit rst, input bit en, input logic [1:0] q,
                        input logic [31:0] a, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      reset_n    = rst;
      en_tangent = en;
      quadrant   = q;
      data_in    = a;
      if (rst) begin
         e = model(32'd0, 2'd0);
      end else if (en) begin
         e = model(a, q);
      end else begin
         e = last_exp;
      end
      last_exp = e;
      e.due  = cyc + 1;
      e.name = nm;
      sbq.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            check(e);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, pending=%0d", sbq.size());
      $fatal(1);
   end

   initial begin : driver
      int budget;
      last_exp = model(32'd0, 2'd0);

      issue(1'b1, 1'b1, 2'd0, 32'd45, "reset_hold0");
      issue(1'b1, 1'b1, 2'd0, 32'd45, "reset_hold1");

      for (int k = 0; k <= 90; k++)
         issue(1'b0, 1'b1, 2'd0, 32'(k), $sformatf("sweep_%0d", k));

      issue(1'b0, 1'b1, 2'd1, 32'd45, "neg_45");
      issue(1'b0, 1'b1, 2'd1, 32'd0,  "neg_0");
      issue(1'b0, 1'b1, 2'd1, 32'd90, "neg_90");

      issue(1'b0, 1'b1, 2'd0, 32'd135, "fold_135");
      issue(1'b0, 1'b1, 2'd0, 32'd225, "fold_225");
      issue(1'b0, 1'b1, 2'd0, 32'd300, "fold_300");
      issue(1'b0, 1'b1, 2'd1, 32'd135, "fold_neg_135");
      issue(1'b0, 1'b1, 2'd1, 32'd225, "fold_neg_225");
      issue(1'b0, 1'b1, 2'd1, 32'd300, "fold_neg_300");
      issue(1'b0, 1'b1, 2'd1, 32'd270, "fold_neg_270");
      issue(1'b0, 1'b1, 2'd0, 32'd180, "fold_180");
      issue(1'b0, 1'b1, 2'd1, 32'd359, "fold_neg_359");

      issue(1'b0, 1'b1, 2'd0, 32'd360,        "oor_360");
      issue(1'b0, 1'b1, 2'd1, 32'hFFFF_FFFF,  "oor_max_neg");
      issue(1'b0, 1'b1, 2'd2, 32'd360,        "oor_360_q2");
      issue(1'b0, 1'b1, 2'd3, 32'h0000_0200,  "oor_512_q3");
      issue(1'b0, 1'b1, 2'd2, 32'd45,         "q1_ignored_45");
      issue(1'b0, 1'b1, 2'd3, 32'd135,        "q1_ignored_135");

      issue(1'b0, 1'b1, 2'd0, 32'd60, "hold_load");
      for (int i = 0; i < 3; i++)
         issue(1'b0, 1'b0, 2'($urandom_range(0, 3)), 32'($urandom_range(0, 359)),
               $sformatf("hold_%0d", i));
      issue(1'b0, 1'b1, 2'd0, 32'd30, "hold_release");

      issue(1'b0, 1'b1, 2'd0, 32'd60, "midrst_load");
      issue(1'b1, 1'b1, 2'd0, 32'd45, "midrst_reset");
      issue(1'b0, 1'b1, 2'd0, 32'd45, "midrst_first");

      for (int i = 0; i < 20; i++)
         issue(1'b0, 1'b1, 2'($urandom_range(0, 3)), 32'($urandom_range(0, 359)),
               $sformatf("rand_%0d", i));

      issue(1'b0, 1'b0, 2'd0, 32'd0, "final_hold");

      budget = 20;
      while (sbq.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      @(posedge clk);
      if (sbq.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: pending=%0d required=0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
